// File: rtl/bus_interconnect.sv
// N-host to M-device interconnect: fixed-priority arbitration, base/mask address decode,
// combinational request path and a one-cycle registered response path.
module bus_interconnect #(
    parameter int unsigned NrDevices    = 1,
    parameter int unsigned NrHosts      = 1,
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned AddressWidth = 32
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,

    input  logic [NrHosts-1:0]                   host_req_i,
    output logic [NrHosts-1:0]                   host_gnt_o,
    input  logic [NrHosts*AddressWidth-1:0]      host_addr_i,
    input  logic [NrHosts-1:0]                   host_we_i,
    input  logic [NrHosts*(DataWidth/8)-1:0]     host_be_i,
    input  logic [NrHosts*DataWidth-1:0]         host_wdata_i,
    output logic [NrHosts-1:0]                   host_rvalid_o,
    output logic [NrHosts*DataWidth-1:0]         host_rdata_o,
    output logic [NrHosts-1:0]                   host_err_o,

    output logic [NrDevices-1:0]                 device_req_o,
    output logic [NrDevices*AddressWidth-1:0]    device_addr_o,
    output logic [NrDevices-1:0]                 device_we_o,
    output logic [NrDevices*(DataWidth/8)-1:0]   device_be_o,
    output logic [NrDevices*DataWidth-1:0]       device_wdata_o,
    input  logic [NrDevices-1:0]                 device_rvalid_i,
    input  logic [NrDevices*DataWidth-1:0]       device_rdata_i,
    input  logic [NrDevices-1:0]                 device_err_i,

    input  logic [NrDevices*AddressWidth-1:0]    cfg_device_addr_base,
    input  logic [NrDevices*AddressWidth-1:0]    cfg_device_addr_mask
);

    localparam int unsigned BeWidth  = DataWidth / 8;
    localparam int unsigned HostIdxW = (NrHosts > 1) ? $clog2(NrHosts) : 1;
    localparam int unsigned DevIdxW  = (NrDevices > 1) ? $clog2(NrDevices) : 1;

    logic [HostIdxW-1:0]     host_sel;
    logic                    host_any;
    logic [DevIdxW-1:0]      dev_sel;
    logic                    dev_hit;

    logic [AddressWidth-1:0] sel_addr;
    logic                    sel_we;
    logic [BeWidth-1:0]      sel_be;
    logic [DataWidth-1:0]    sel_wdata;

    logic [HostIdxW-1:0]     resp_host_d, resp_host_q;
    logic [DevIdxW-1:0]      resp_dev_d, resp_dev_q;
    logic                    resp_miss_d, resp_miss_q;

    // Fixed priority: lowest-index requesting host wins; host 0 when idle.
    always_comb begin
        host_sel = '0;
        host_any = 1'b0;
        for (int unsigned h = 0; h < NrHosts; h++) begin
            if (!host_any && host_req_i[h]) begin
                host_sel = HostIdxW'(h);
                host_any = 1'b1;
            end
        end
    end

    always_comb begin
        sel_addr  = host_addr_i[AddressWidth-1:0];
        sel_we    = host_we_i[0];
        sel_be    = host_be_i[BeWidth-1:0];
        sel_wdata = host_wdata_i[DataWidth-1:0];
        for (int unsigned h = 0; h < NrHosts; h++) begin
            if (HostIdxW'(h) == host_sel) begin
                sel_addr  = host_addr_i[h*AddressWidth +: AddressWidth];
                sel_we    = host_we_i[h];
                sel_be    = host_be_i[h*BeWidth +: BeWidth];
                sel_wdata = host_wdata_i[h*DataWidth +: DataWidth];
            end
        end
    end

    always_comb begin
        dev_sel = '0;
        dev_hit = 1'b0;
        for (int unsigned d = 0; d < NrDevices; d++) begin
            if (!dev_hit &&
                ((sel_addr & cfg_device_addr_mask[d*AddressWidth +: AddressWidth]) ==
                 cfg_device_addr_base[d*AddressWidth +: AddressWidth])) begin
                dev_sel = DevIdxW'(d);
                dev_hit = 1'b1;
            end
        end
    end

    always_comb begin
        host_gnt_o = '0;
        for (int unsigned h = 0; h < NrHosts; h++) begin
            host_gnt_o[h] = host_req_i[h] && (HostIdxW'(h) == host_sel);
        end
    end

    // Only the decoded device sees the request; a decode miss leaves every device idle.
    always_comb begin
        device_req_o   = '0;
        device_addr_o  = '0;
        device_we_o    = '0;
        device_be_o    = '0;
        device_wdata_o = '0;
        for (int unsigned d = 0; d < NrDevices; d++) begin
            if (dev_hit && (DevIdxW'(d) == dev_sel)) begin
                device_req_o[d]                               = host_any;
                device_addr_o[d*AddressWidth +: AddressWidth] = sel_addr;
                device_we_o[d]                                = sel_we;
                device_be_o[d*BeWidth +: BeWidth]             = sel_be;
                device_wdata_o[d*DataWidth +: DataWidth]      = sel_wdata;
            end
        end
    end

    always_comb begin
        resp_host_d = host_sel;
        resp_dev_d  = dev_sel;
        resp_miss_d = host_any && !dev_hit;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            resp_host_q <= '0;
            resp_dev_q  <= '0;
            resp_miss_q <= 1'b0;
        end else begin
            resp_host_q <= resp_host_d;
            resp_dev_q  <= resp_dev_d;
            resp_miss_q <= resp_miss_d;
        end
    end

    // A decode miss answers with an error on its own; reset silences the response path.
    always_comb begin
        host_rvalid_o = '0;
        host_rdata_o  = '0;
        host_err_o    = '0;
        if (!rst_i) begin
            for (int unsigned h = 0; h < NrHosts; h++) begin
                if (HostIdxW'(h) == resp_host_q) begin
                    if (resp_miss_q) begin
                        host_rvalid_o[h] = 1'b1;
                        host_err_o[h]    = 1'b1;
                    end else begin
                        for (int unsigned d = 0; d < NrDevices; d++) begin
                            if (DevIdxW'(d) == resp_dev_q) begin
                                host_rvalid_o[h]                       = device_rvalid_i[d];
                                host_rdata_o[h*DataWidth +: DataWidth] =
                                    device_rdata_i[d*DataWidth +: DataWidth];
                                host_err_o[h]                          = device_err_i[d];
                            end
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_bus_interconnect.sv
// Scoreboard bench for bus_interconnect with two hosts and the RAM / SimCtrl / Timer map.
module tb_bus_interconnect;

    localparam int NH = 2;
    localparam int ND = 3;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int BW = DW / 8;

    localparam logic [ND*AW-1:0] CfgBase = {32'h0003_0000, 32'h0002_0000, 32'h0010_0000};
    localparam logic [ND*AW-1:0] CfgMask = {32'hFFFF_FC00, 32'hFFFF_FC00, 32'hFFF0_0000};

    logic              clk = 1'b0;
    logic              rst;
    logic [NH-1:0]     host_req_i;
    logic [NH-1:0]     host_gnt_o;
    logic [NH*AW-1:0]  host_addr_i;
    logic [NH-1:0]     host_we_i;
    logic [NH*BW-1:0]  host_be_i;
    logic [NH*DW-1:0]  host_wdata_i;
    logic [NH-1:0]     host_rvalid_o;
    logic [NH*DW-1:0]  host_rdata_o;
    logic [NH-1:0]     host_err_o;
    logic [ND-1:0]     device_req_o;
    logic [ND*AW-1:0]  device_addr_o;
    logic [ND-1:0]     device_we_o;
    logic [ND*BW-1:0]  device_be_o;
    logic [ND*DW-1:0]  device_wdata_o;
    logic [ND-1:0]     device_rvalid_i;
    logic [ND*DW-1:0]  device_rdata_i;
    logic [ND-1:0]     device_err_i;
    logic [ND*AW-1:0]  cfg_base;
    logic [ND*AW-1:0]  cfg_mask;

    assign cfg_base = CfgBase;
    assign cfg_mask = CfgMask;

    always #5 clk = ~clk;

    bus_interconnect #(
        .NrDevices    (ND),
        .NrHosts      (NH),
        .DataWidth    (DW),
        .AddressWidth (AW)
    ) dut (
        .clk_i                (clk),
        .rst_i                (rst),
        .host_req_i           (host_req_i),
        .host_gnt_o           (host_gnt_o),
        .host_addr_i          (host_addr_i),
        .host_we_i            (host_we_i),
        .host_be_i            (host_be_i),
        .host_wdata_i         (host_wdata_i),
        .host_rvalid_o        (host_rvalid_o),
        .host_rdata_o         (host_rdata_o),
        .host_err_o           (host_err_o),
        .device_req_o         (device_req_o),
        .device_addr_o        (device_addr_o),
        .device_we_o          (device_we_o),
        .device_be_o          (device_be_o),
        .device_wdata_o       (device_wdata_o),
        .device_rvalid_i      (device_rvalid_i),
        .device_rdata_i       (device_rdata_i),
        .device_err_i         (device_err_i),
        .cfg_device_addr_base (cfg_base),
        .cfg_device_addr_mask (cfg_mask)
    );

    typedef struct {
        int              due;
        logic [NH-1:0]   rv;
        logic [NH-1:0]   er;
        logic [NH*DW-1:0] rd;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    // Host transaction state; a host holds its request until granted.
    logic        h_req[NH];
    logic [31:0] h_addr[NH];
    logic        h_we[NH];
    logic [3:0]  h_be[NH];
    logic [31:0] h_wdata[NH];

    // Device model: what the devices drive in the following cycle.
    logic [ND-1:0]    pend_rv;
    logic [ND-1:0]    pend_er;
    logic [ND*DW-1:0] pend_rd;
    logic             rst_next;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int decode(input logic [31:0] a);
        if ((a & 32'hFFF0_0000) == 32'h0010_0000) return 0;
        if ((a & 32'hFFFF_FC00) == 32'h0002_0000) return 1;
        if ((a & 32'hFFFF_FC00) == 32'h0003_0000) return 2;
        return -1;
    endfunction

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 4))
            0:       return 32'h0010_0000 | ($urandom & 32'h000F_FFFC);
            1:       return 32'h0002_0000 | ($urandom & 32'h0000_03FC);
            2:       return 32'h0003_0000 | ($urandom & 32'h0000_03FC);
            3:       return 32'h0050_0000 | ($urandom & 32'h0000_FFFC);
            default: return $urandom;
        endcase
    endfunction

    // One bus cycle: drive at posedge+1, evaluate the request path at negedge.
    task automatic cycle_go(input logic [31:0] rd, input logic er);
        int               sel;
        int               hs;
        int               dev;
        logic [NH-1:0]    e_gnt;
        logic [ND-1:0]    e_req;
        logic [ND-1:0]    e_we;
        logic [ND*AW-1:0] e_addr;
        logic [ND*BW-1:0] e_be;
        logic [ND*DW-1:0] e_wd;
        exp_t             e;
        @(posedge clk);
        #1;
        cyc++;
        rst             = rst_next;
        device_rvalid_i = pend_rv;
        device_err_i    = pend_er;
        device_rdata_i  = pend_rd;
        pend_rv = '0;
        pend_er = '0;
        pend_rd = '0;
        for (int h = 0; h < NH; h++) begin
            host_req_i[h]             = h_req[h];
            host_addr_i[h*AW +: AW]   = h_addr[h];
            host_we_i[h]              = h_we[h];
            host_be_i[h*BW +: BW]     = h_be[h];
            host_wdata_i[h*DW +: DW]  = h_wdata[h];
        end
        @(negedge clk);
        sel = -1;
        for (int h = 0; h < NH; h++) if (sel < 0 && h_req[h]) sel = h;
        hs  = (sel < 0) ? 0 : sel;
        dev = decode(h_addr[hs]);
        e_gnt = '0; e_req = '0; e_we = '0; e_addr = '0; e_be = '0; e_wd = '0;
        if (sel >= 0) e_gnt[sel] = 1'b1;
        if (dev >= 0) begin
            e_req[dev]           = (sel >= 0);
            e_addr[dev*AW +: AW] = h_addr[hs];
            e_we[dev]            = h_we[hs];
            e_be[dev*BW +: BW]   = h_be[hs];
            e_wd[dev*DW +: DW]   = h_wdata[hs];
        end
        check("host_gnt", 128'(host_gnt_o), 128'(e_gnt));
        check("device_req", 128'(device_req_o), 128'(e_req));
        check("device_addr", 128'(device_addr_o), 128'(e_addr));
        check("device_we", 128'(device_we_o), 128'(e_we));
        check("device_be", 128'(device_be_o), 128'(e_be));
        check("device_wdata", 128'(device_wdata_o), 128'(e_wd));
        if (sel >= 0 && !rst) begin
            e.due = cyc + 1;
            e.rv  = '0;
            e.er  = '0;
            e.rd  = '0;
            e.rv[sel] = 1'b1;
            if (dev >= 0) begin
                e.er[sel]            = er;
                e.rd[sel*DW +: DW]   = rd;
                pend_rv[dev]         = 1'b1;
                pend_er[dev]         = er;
                pend_rd[dev*DW +: DW] = rd;
            end else begin
                // Junk on the device response lines must not leak through a miss.
                e.er[sel] = 1'b1;
                pend_rv   = ND'($urandom);
                pend_er   = ND'($urandom);
                pend_rd   = {$urandom, $urandom, $urandom};
            end
            exp_q.push_back(e);
        end
        if (sel >= 0) h_req[sel] = 1'b0;
    endtask

    task automatic set_host(input int h, input logic [31:0] a, input logic we,
                            input logic [3:0] be, input logic [31:0] wd);
        h_req[h]   = 1'b1;
        h_addr[h]  = a;
        h_we[h]    = we;
        h_be[h]    = be;
        h_wdata[h] = wd;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            mon_e = exp_q.pop_front();
            check("host_rvalid", 128'(host_rvalid_o), 128'(mon_e.rv));
            check("host_rdata", 128'(host_rdata_o), 128'(mon_e.rd));
            check("host_err", 128'(host_err_o), 128'(mon_e.er));
        end else if (host_rvalid_o !== '0) begin
            check("unexpected_rvalid", 128'(host_rvalid_o), 128'(0));
        end
    end

    initial begin
        exp_t last;
        rst = 1'b1;
        rst_next = 1'b1;
        host_req_i = '0; host_addr_i = '0; host_we_i = '0; host_be_i = '0; host_wdata_i = '0;
        device_rvalid_i = '0; device_rdata_i = '0; device_err_i = '0;
        pend_rv = '0; pend_er = '0; pend_rd = '0;
        for (int h = 0; h < NH; h++) begin
            h_req[h] = 1'b0; h_addr[h] = '0; h_we[h] = 1'b0; h_be[h] = '0; h_wdata[h] = '0;
        end

        // During reset: request path still live, response outputs forced to zero.
        set_host(0, 32'h0010_0040, 1'b0, 4'hF, 32'h0);
        pend_rv = '1;
        pend_er = '1;
        pend_rd = {32'hAAAA_5555, 32'h1234_5678, 32'hCAFE_F00D};
        cycle_go(32'h0, 1'b0);
        check("reset_rvalid", 128'(host_rvalid_o), 128'(0));
        check("reset_err", 128'(host_err_o), 128'(0));
        check("reset_rdata", 128'(host_rdata_o), 128'(0));
        rst_next = 1'b0;
        cycle_go(32'h0, 1'b0);
        cycle_go(32'h0, 1'b0);

        // RAM read, SimCtrl write.
        set_host(0, 32'h0010_0040, 1'b0, 4'hF, 32'h0);
        cycle_go(32'hDEAD_BEEF, 1'b0);
        set_host(0, 32'h0002_0008, 1'b1, 4'hF, 32'h41);
        cycle_go(32'h0000_0000, 1'b0);
        cycle_go(32'h0, 1'b0);

        // Back-to-back RAM then Timer with error.
        set_host(0, 32'h0010_0080, 1'b0, 4'hF, 32'h0);
        cycle_go(32'h1111_2222, 1'b0);
        set_host(0, 32'h0003_0004, 1'b0, 4'hF, 32'h0);
        cycle_go(32'h3333_4444, 1'b1);
        cycle_go(32'h0, 1'b0);

        // Decode miss.
        set_host(0, 32'h0050_0000, 1'b0, 4'hF, 32'h0);
        cycle_go(32'h0, 1'b0);
        cycle_go(32'h0, 1'b0);

        // Arbitration: host1 waits while host0 keeps requesting.
        set_host(0, 32'h0010_0100, 1'b0, 4'h3, 32'h0);
        set_host(1, 32'h0003_0010, 1'b1, 4'hC, 32'h5A5A_0001);
        cycle_go(32'h5555_0000, 1'b0);
        set_host(0, 32'h0002_0020, 1'b1, 4'h1, 32'h77);
        cycle_go(32'h5555_0001, 1'b0);
        cycle_go(32'h5555_0002, 1'b0);
        cycle_go(32'h0, 1'b0);

        // Reset asserted the cycle after a grant drops the pending response.
        set_host(0, 32'h0010_0200, 1'b0, 4'hF, 32'h0);
        cycle_go(32'hBAD0_BAD0, 1'b0);
        last = exp_q.pop_back();
        last.rv = '0;
        last.er = '0;
        last.rd = '0;
        exp_q.push_back(last);
        rst_next = 1'b1;
        cycle_go(32'h0, 1'b0);
        rst_next = 1'b0;
        cycle_go(32'h0, 1'b0);
        set_host(0, 32'h0010_0204, 1'b0, 4'hF, 32'h0);
        cycle_go(32'h600D_600D, 1'b0);
        cycle_go(32'h0, 1'b0);

        // Randomised traffic.
        for (int n = 0; n < 500; n++) begin
            for (int h = 0; h < NH; h++) begin
                if (!h_req[h] && $urandom_range(0, 99) < 55) begin
                    set_host(h, rand_addr(), 1'($urandom), 4'($urandom), $urandom);
                end
            end
            cycle_go($urandom, ($urandom_range(0, 3) == 0));
        end
        for (int h = 0; h < NH; h++) h_req[h] = 1'b0;
        for (int n = 0; n < 4; n++) cycle_go(32'h0, 1'b0);
        check("scoreboard_drained", 128'(exp_q.size()), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
